seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader_pkg.sv | 32 +++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_reader.sv | 135 +++++++++++++
 tb/tb_seg7_reader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_reader_pkg.sv
// Shared definitions for the two-digit seven-segment reader: segment codes
// (active-low {a..g}, a = bit 6), the blank code, FSM states and a BCD helper.
package seg7_reader_pkg;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h60;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h0C;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [13:0] SEG_PAIR_BLANK = {SEG_BLANK, SEG_BLANK};

  typedef enum logic [1:0] {
    ST_SETTLE   = 2'd0,
    ST_VALID    = 2'd1,
    ST_WAIT_CHG = 2'd2
  } state_e;

  // tens*10 + ones as shift-and-add; 9*10+9 = 99 fits in 7 bits.
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] o);
    logic [6:0] tw;
    tw = {3'b000, t};
    return (tw << 3) + (tw << 1) + {3'b000, o};
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps one 7-bit active-low segment pattern to a decimal digit; any pattern
// outside the ten legal codes raises illegal_o and returns digit 0xF.
module seg7_pattern_decode
  import seg7_reader_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] digit_o,
  output logic       illegal_o
);

  always_comb begin
    digit_o   = 4'hF;
    illegal_o = 1'b0;
    case (pattern_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples an asynchronous two-digit seven-segment display, waits for the
// pattern to settle and presents each new reading once over valid/ready.
// Optional macro SEG7_READER_BLANK_EN: blank tens digit reads as 0 (not an error).
module seg7_reader
  import seg7_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_hi,
  input  logic [6:0] seg_lo,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] value,
  output logic       err
);

  localparam logic [3:0] CAPTURE_AT = 4'(STABLE_CYCLES - 1);

  logic [13:0] sync1_q, sync2_q, prev_q;
  logic [13:0] last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [6:0]  value_q, value_d;

  logic [3:0]  hi_digit, lo_digit, hi_digit_eff;
  logic        hi_illegal, lo_illegal, hi_illegal_eff;
  logic        pair_stable, read_err;

  seg7_pattern_decode u_dec_hi (
    .pattern_i (sync2_q[13:7]),
    .digit_o   (hi_digit),
    .illegal_o (hi_illegal)
  );

  seg7_pattern_decode u_dec_lo (
    .pattern_i (sync2_q[6:0]),
    .digit_o   (lo_digit),
    .illegal_o (lo_illegal)
  );

  always_comb begin
    hi_digit_eff   = hi_digit;
    hi_illegal_eff = hi_illegal;
`ifdef SEG7_READER_BLANK_EN
    if (sync2_q[13:7] == SEG_BLANK) begin
      hi_digit_eff   = 4'd0;
      hi_illegal_eff = 1'b0;
    end
`endif
  end

  assign read_err    = hi_illegal_eff | lo_illegal;
  assign pair_stable = (sync2_q == prev_q);

  // The extra pair_stable term keeps a late glitch from being captured.
  always_comb begin
    cnt_d   = pair_stable ? ((cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1) : 4'd0;
    state_d = state_q;
    last_d  = last_q;
    valid_d = valid_q;
    err_d   = err_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    value_d = value_q;
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q >= CAPTURE_AT && pair_stable) begin
          last_d  = sync2_q;
          valid_d = 1'b1;
          err_d   = read_err;
          tens_d  = read_err ? 4'hF : hi_digit_eff;
          ones_d  = read_err ? 4'hF : lo_digit;
          value_d = read_err ? 7'd0 : bcd_to_bin(hi_digit_eff, lo_digit);
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_WAIT_CHG;
        end
      end
      ST_WAIT_CHG: begin
        if (sync2_q != last_q) begin
          cnt_d   = 4'd0;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= SEG_PAIR_BLANK;
      sync2_q <= SEG_PAIR_BLANK;
      prev_q  <= SEG_PAIR_BLANK;
      last_q  <= SEG_PAIR_BLANK;
      cnt_q   <= 4'd0;
      state_q <= ST_SETTLE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      value_q <= 7'd0;
    end else begin
      sync1_q <= {seg_hi, seg_lo};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      value_q <= value_d;
    end
  end

  assign out_valid = valid_q;
  assign err       = err_q;
  assign tens      = tens_q;
  assign ones      = ones_q;
  assign value     = value_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader with STABLE_CYCLES = 4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_hi;
  logic [6:0] seg_lo;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] value;
  logic       err;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [6:0] digitCode [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                 7'h24, 7'h60, 7'h0F, 7'h00, 7'h0C};

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_hi    (seg_hi),
    .seg_lo    (seg_lo),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .tens      (tens),
    .ones      (ones),
    .value     (value),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [6:0] hi, input logic [6:0] lo, input logic ready);
    seg_hi    = hi;
    seg_lo    = lo;
    out_ready = ready;
  endtask

  function automatic logic [16:0] expVec(input logic v, input logic [3:0] t, input logic [3:0] o,
                                         input logic [6:0] val, input logic e);
    return {v, t, o, val, e};
  endfunction

  task automatic checkOutput(input string tag, input logic [16:0] expected);
    logic [16:0] observed;
    observed = {out_valid, tens, ones, value, err};
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed valid=%0b tens=%h ones=%h value=%0d err=%0b, expected valid=%0b tens=%h ones=%h value=%0d err=%0b",
             tag, observed[16], observed[15:12], observed[11:8], observed[7:1], observed[0],
             expected[16], expected[15:12], expected[11:8], expected[7:1], expected[0]);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Bounded wait: returns the number of edges until out_valid, or limit on timeout.
  task automatic waitValid(input int limit, output int ticks);
    ticks = 0;
    do begin
      tick(1);
      ticks++;
    end while (!out_valid && ticks < limit);
  endtask

  initial begin
    int ticks;
    int seen;
    logic [16:0] captured;
    logic [16:0] blankExp;

    rst = 1'b1;
    applyStimulus(7'h4F, 7'h24, 1'b1);
    tick(3);
    checkOutput("reset_state", expVec(1'b0, 4'd0, 4'd0, 7'd0, 1'b0));
    rst = 1'b0;

    // Steady 15 with ready held high: valid exactly on the 7th edge, one cycle wide.
    tick(6);
    checkOutput("latency_not_yet", expVec(1'b0, 4'd0, 4'd0, 7'd0, 1'b0));
    tick(1);
    checkOutput("read_15", expVec(1'b1, 4'd1, 4'd5, 7'd15, 1'b0));
    tick(1);
    checkOutput("read_15_pulse", expVec(1'b0, 4'd1, 4'd5, 7'd15, 1'b0));

    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (out_valid) seen++;
    end
    checkValue("no_repeat_15", seen, 0);

    // Bouncing ones digit never settles long enough to be reported.
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(7'h4F, (i % 2 == 0) ? 7'h12 : 7'h06, 1'b1);
      for (int k = 0; k < 2; k++) begin
        tick(1);
        if (out_valid) seen++;
      end
    end
    checkValue("toggle_no_valid", seen, 0);

    seen = 0;
    captured = '0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (out_valid) begin
        seen++;
        captured = {out_valid, tens, ones, value, err};
      end
    end
    checkValue("settled_once", seen, 1);
    checkValue("settled_13", int'(captured), int'(expVec(1'b1, 4'd1, 4'd3, 7'd13, 1'b0)));

    // Reading 08 held without ready while inputs move to 99.
    applyStimulus(7'h01, 7'h00, 1'b0);
    waitValid(20, ticks);
    checkValue("latency_08", ticks, 7);
    checkOutput("read_08", expVec(1'b1, 4'd0, 4'd8, 7'd8, 1'b0));
    applyStimulus(7'h0C, 7'h0C, 1'b0);
    tick(10);
    checkOutput("hold_08", expVec(1'b1, 4'd0, 4'd8, 7'd8, 1'b0));
    applyStimulus(7'h0C, 7'h0C, 1'b1);
    tick(1);
    checkOutput("handshake_08", expVec(1'b0, 4'd0, 4'd8, 7'd8, 1'b0));
    waitValid(20, ticks);
    checkValue("resettle_ticks", ticks, 5);
    checkOutput("read_99", expVec(1'b1, 4'd9, 4'd9, 7'd99, 1'b0));
    tick(1);

    applyStimulus(7'h4F, 7'h7E, 1'b1);
    waitValid(20, ticks);
    checkValue("latency_illegal", ticks, 7);
    checkOutput("illegal_lo", expVec(1'b1, 4'hF, 4'hF, 7'd0, 1'b1));
    tick(1);

`ifdef SEG7_READER_BLANK_EN
    blankExp = expVec(1'b1, 4'd0, 4'd7, 7'd7, 1'b0);
`else
    blankExp = expVec(1'b1, 4'hF, 4'hF, 7'd0, 1'b1);
`endif
    applyStimulus(7'h7F, 7'h0F, 1'b1);
    waitValid(20, ticks);
    checkOutput("blank_hi_07", blankExp);
    tick(1);

    applyStimulus(7'h01, 7'h7F, 1'b1);
    waitValid(20, ticks);
    checkOutput("blank_lo", expVec(1'b1, 4'hF, 4'hF, 7'd0, 1'b1));
    tick(1);

    // Every legal code on both digits; tens + ones = 9 so each pair is new.
    for (int d = 0; d < 10; d++) begin
      applyStimulus(digitCode[9 - d], digitCode[d], 1'b1);
      waitValid(20, ticks);
      checkOutput($sformatf("sweep_%0d%0d", 9 - d, d),
                  expVec(1'b1, 4'(9 - d), 4'(d), 7'((9 - d) * 10 + d), 1'b0));
      tick(1);
    end

    // Reset while a reading is pending drops it; the same input is reported again.
    applyStimulus(7'h06, 7'h4C, 1'b0);
    waitValid(20, ticks);
    checkOutput("read_34", expVec(1'b1, 4'd3, 4'd4, 7'd34, 1'b0));
    rst = 1'b1;
    tick(1);
    checkOutput("reset_mid_valid", expVec(1'b0, 4'd0, 4'd0, 7'd0, 1'b0));
    rst = 1'b0;
    waitValid(20, ticks);
    checkValue("rereport_ticks", ticks, 7);
    checkOutput("rereport_34", expVec(1'b1, 4'd3, 4'd4, 7'd34, 1'b0));
    applyStimulus(7'h06, 7'h4C, 1'b1);
    tick(1);
    checkOutput("rereport_done", expVec(1'b0, 4'd3, 4'd4, 7'd34, 1'b0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
